// File: rtl/pc_pkg.sv
// Shared IF-stage constants: architectural word width and PC reset value.
// Also used by the debug unit so both agree on where execution restarts.
package pc_pkg;

    localparam int                           ARQUITECTURE_BITS = 32;
    localparam logic [ARQUITECTURE_BITS-1:0] PC_RESET_VALUE    = '0;

endpackage : pc_pkg

// File: rtl/pc.sv
// Program-counter register of the IF stage.
// Flush and clear force the restart address. Otherwise a load happens only when
// the debug unit enables the step and neither halt nor a hazard stall is active.
// o_pc is the register output with no combinational path from any input.
module pc
    import pc_pkg::*;
#(
    parameter int PC_SIZE = ARQUITECTURE_BITS
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_flush,
    input  logic               i_clear,
    input  logic               i_halt,
    input  logic               i_not_load,
    input  logic               i_enable,
    input  logic [PC_SIZE-1:0] i_next_pc,
    output logic [PC_SIZE-1:0] o_pc
);

    // Restart address, resized to this instance's PC width.
    localparam logic [PC_SIZE-1:0] RST_PC = PC_SIZE'(PC_RESET_VALUE);

    logic [PC_SIZE-1:0] pc_q;
    logic               restart;
    logic               load;

    // Flush and clear both take priority over every hold condition.
    always_comb begin
        restart = i_flush | i_clear;
        load    = i_enable & ~i_halt & ~i_not_load;
    end

    // PC register: async reset. Restart has priority over load; otherwise hold.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            pc_q <= RST_PC;
        else if (restart)
            pc_q <= RST_PC;
        else if (load)
            pc_q <= i_next_pc;
    end

    assign o_pc = pc_q;

endmodule : pc

// File: tb/tb_pc.sv
// Directed self-checking bench for the IF-stage program counter.
module tb_pc;

    localparam int W = 32;

    logic         i_clk;
    logic         i_reset;
    logic         i_flush;
    logic         i_clear;
    logic         i_halt;
    logic         i_not_load;
    logic         i_enable;
    logic [W-1:0] i_next_pc;
    logic [W-1:0] o_pc;

    int checks = 0;
    int errors = 0;

    pc #(.PC_SIZE(W)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_flush    (i_flush),
        .i_clear    (i_clear),
        .i_halt     (i_halt),
        .i_not_load (i_not_load),
        .i_enable   (i_enable),
        .i_next_pc  (i_next_pc),
        .o_pc       (o_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset    = 1'b0;
        i_flush    = 1'b0;
        i_clear    = 1'b0;
        i_halt     = 1'b0;
        i_not_load = 1'b0;
        i_enable   = 1'b1;
        i_next_pc  = 32'd5;
        #2;
        checks++;
        if (o_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_async: got %0h expected 0", o_pc);
        end
        i_reset = 1'b1;
        #1;
        checks++;
        if (o_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_release_no_edge: got %0h expected 0", o_pc);
        end
        step();
        checks++;
        if (o_pc !== 32'd5) begin
            errors++;
            $display("FAIL reset_first_load: got %0h expected 5", o_pc);
        end
    endtask

    task automatic test_normal_load();
        for (int v = 0; v <= 10; v++) begin
            i_next_pc = W'(v);
            step();
            checks++;
            if (o_pc !== W'(v)) begin
                errors++;
                $display("FAIL normal_load_%0d: got %0h expected %0h", v, o_pc, v);
            end
        end
    endtask

    task automatic test_enable_halt_hold();
        i_enable  = 1'b0;
        i_next_pc = 32'd20;
        step();
        step();
        checks++;
        if (o_pc !== 32'd10) begin
            errors++;
            $display("FAIL enable_hold: got %0h expected a", o_pc);
        end
        i_halt    = 1'b1;
        i_enable  = 1'b1;
        i_next_pc = 32'd25;
        step();
        step();
        checks++;
        if (o_pc !== 32'd10) begin
            errors++;
            $display("FAIL halt_hold: got %0h expected a", o_pc);
        end
    endtask

    task automatic test_flush_resume();
        i_halt  = 1'b0;
        i_flush = 1'b1;
        step();
        checks++;
        if (o_pc !== 32'd0) begin
            errors++;
            $display("FAIL flush_zero: got %0h expected 0", o_pc);
        end
        step();
        checks++;
        if (o_pc !== 32'd0) begin
            errors++;
            $display("FAIL flush_held: got %0h expected 0", o_pc);
        end
        i_flush   = 1'b0;
        i_next_pc = 32'd35;
        step();
        checks++;
        if (o_pc !== 32'd35) begin
            errors++;
            $display("FAIL flush_resume: got %0h expected 23", o_pc);
        end
    endtask

    task automatic test_stall();
        i_not_load = 1'b1;
        i_next_pc  = 32'd40;
        step();
        checks++;
        if (o_pc !== 32'd35) begin
            errors++;
            $display("FAIL stall_hold: got %0h expected 23", o_pc);
        end
        i_next_pc = 32'd41;
        step();
        checks++;
        if (o_pc !== 32'd35) begin
            errors++;
            $display("FAIL stall_ignore_change: got %0h expected 23", o_pc);
        end
        i_not_load = 1'b0;
        i_next_pc  = 32'd45;
        step();
        checks++;
        if (o_pc !== 32'd45) begin
            errors++;
            $display("FAIL stall_release: got %0h expected 2d", o_pc);
        end
    endtask

    task automatic test_priority();
        i_clear    = 1'b1;
        i_not_load = 1'b1;
        i_halt     = 1'b1;
        step();
        checks++;
        if (o_pc !== 32'd0) begin
            errors++;
            $display("FAIL clear_over_holds: got %0h expected 0", o_pc);
        end
        i_clear    = 1'b0;
        i_not_load = 1'b0;
        i_halt     = 1'b0;
        step();
        checks++;
        if (o_pc !== 32'd45) begin
            errors++;
            $display("FAIL clear_resume: got %0h expected 2d", o_pc);
        end
        i_flush    = 1'b1;
        i_halt     = 1'b1;
        i_not_load = 1'b1;
        i_enable   = 1'b0;
        step();
        checks++;
        if (o_pc !== 32'd0) begin
            errors++;
            $display("FAIL flush_over_holds: got %0h expected 0", o_pc);
        end
        i_flush    = 1'b0;
        i_halt     = 1'b0;
        i_not_load = 1'b0;
        i_enable   = 1'b1;
        step();
        checks++;
        if (o_pc !== 32'd45) begin
            errors++;
            $display("FAIL flush_holds_resume: got %0h expected 2d", o_pc);
        end
    endtask

    task automatic test_wide_values();
        i_next_pc = 32'hFFFF_FFFF;
        step();
        checks++;
        if (o_pc !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL all_ones: got %0h expected ffffffff", o_pc);
        end
        i_next_pc = 32'hA5A5_5A5A;
        step();
        checks++;
        if (o_pc !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL pattern: got %0h expected a5a55a5a", o_pc);
        end
        i_next_pc = 32'd45;
        step();
        checks++;
        if (o_pc !== 32'd45) begin
            errors++;
            $display("FAIL back_to_45: got %0h expected 2d", o_pc);
        end
    endtask

    task automatic test_async_reset();
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        checks++;
        if (o_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_midrun_async: got %0h expected 0", o_pc);
        end
        step();
        checks++;
        if (o_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_held_over_edge: got %0h expected 0", o_pc);
        end
        i_reset = 1'b1;
        step();
        checks++;
        if (o_pc !== 32'd45) begin
            errors++;
            $display("FAIL reset_midrun_release: got %0h expected 2d", o_pc);
        end
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_enable_halt_hold();
        test_flush_resume();
        test_stall();
        test_priority();
        test_wide_values();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pc

// File: doc/pc.md
Name: pc

Overview:
- Program-counter register of the MIPS instruction-fetch (IF) stage.
- Holds the current fetch address and presents it on o_pc.
- Loads i_next_pc (computed upstream by PC+4/branch/jump muxing) on each enabled clock edge.
- Supports pipeline flush, debug clear, halt, and hazard-stall (not_load) hold conditions.

Parameters:
- PC_SIZE, default 32, width in bits of the program counter and of i_next_pc/o_pc.

Ports:
- i_clk  input  1  system clock; all synchronous updates on the rising edge
- i_reset  input  1  asynchronous, active-low reset; forces o_pc to 0
- i_flush  input  1  synchronous pipeline flush; PC returns to 0
- i_clear  input  1  synchronous debug/program clear; PC returns to 0
- i_halt  input  1  processor halted (HALT instruction retired); PC holds
- i_not_load  input  1  hazard-unit stall; PC holds
- i_enable  input  1  global step/run enable from debug unit; PC holds when low
- i_next_pc  input  PC_SIZE  next fetch address
- o_pc  output  PC_SIZE  current fetch address (registered)

Behaviour:
- Single register pc_q of PC_SIZE bits; o_pc = pc_q directly, no combinational path from any input.
- Asynchronous reset: i_reset low forces pc_q = 0 immediately, independent of the clock. pc_q stays 0 while i_reset is low.
- Release of i_reset takes effect on the next rising edge. No extra latency.
- Rising-edge update priority, highest first:
  1. i_flush = 1 → pc_q <= 0, regardless of enable/halt/not_load.
  2. i_clear = 1 → pc_q <= 0, regardless of enable/halt/not_load.
  3. i_enable = 1 and i_halt = 0 and i_not_load = 0 → pc_q <= i_next_pc.
  4. Otherwise → pc_q holds.
- Latency: one clock. A value on i_next_pc that is stable before an enabled edge appears on o_pc right after that edge.
- i_halt holds the PC for as long as it is asserted. Deasserting it resumes loading on the next enabled edge; no state is remembered.
- i_not_load is a level-sensitive stall with no one-shot behaviour. While it is high, changes on i_next_pc are ignored.
- Simultaneous i_flush with i_halt or i_not_load: the flush wins and the PC becomes 0.
- After a flush or clear with loading re-enabled, the next edge loads i_next_pc normally. The PC then tracks i_next_pc, not an internal increment.
- No wrap or arithmetic is performed internally. All PC_SIZE bits are stored verbatim.
- Inputs are assumed synchronous to i_clk except i_reset. i_reset deassertion must meet recovery/removal timing, which is the integrator's responsibility.

Decomposition:
- Shared package or include holds ARQUITECTURE_BITS (32) and the PC reset value constant (0); both are used by the IF stage and the debug unit.
- No sub-module. A single always block with async reset is sufficient. The IF stage top instantiates pc alongside the PC adder and next-PC mux.

Test Plan:
- Reset: i_reset low at time 0 with i_next_pc = 5 and i_enable = 1 → o_pc = 0 with no clock edge needed; after release, the next edge gives o_pc = 5.
- Normal load: i_enable = 1, halt, not_load and flush all 0, i_next_pc stepped 0→10 across edges → o_pc = 10, each value appearing one edge after it is applied.
- Enable/halt hold:
  - i_enable = 0, i_next_pc stepped to 20 → o_pc stays 10.
  - Then i_halt = 1, i_enable = 1, i_next_pc stepped to 25 → o_pc stays 10.
- Flush then resume: with i_halt = 0, pulse i_flush for 1+ cycles → o_pc = 0; then step i_next_pc 25→35 → o_pc = 35.
- Stall: i_not_load = 1, i_next_pc stepped to 40 → o_pc stays 35; deassert and step to 45 → o_pc = 45.
- Priority:
  - i_clear = 1 together with i_not_load = 1 and i_halt = 1 → o_pc = 0.
  - Assert i_reset low mid-run at o_pc = 45 → o_pc = 0 asynchronously, before the next edge.
